// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, frame state encoding and key-event field layout.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam int unsigned KEY_W       = 11;
  localparam int unsigned KEY_TOGGLE  = 10;
  localparam int unsigned KEY_PRESSED = 9;
  localparam int unsigned KEY_EXT     = 8;

  localparam int unsigned SKIP_W      = 3;
  localparam logic [SKIP_W-1:0] PAUSE_SKIP  = 3'd7;
  localparam logic [9:0]        PAUSE_EVENT = 10'h377;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

  // Device replies that carry no key meaning when no prefix is pending
  function automatic logic is_reply_code(input logic [7:0] code);
    return (code == 8'hFA) || (code == 8'hAA) || (code == 8'hEE) ||
           (code == 8'hFE) || (code == 8'h00) || (code == 8'hFF);
  endfunction

  // E0 12 / E0 59 are the fake shifts some keyboards wrap around extended keys
  function automatic logic is_fake_shift(input logic [7:0] code);
    return (code == 8'h12) || (code == 8'h59);
  endfunction

endpackage

// File: rtl/ps2_host_rx_if.sv
// PS/2 line inputs plus received byte / key event outputs of one port.
interface ps2_host_rx_if;
  import ps2_pkg::*;

  logic              ps2_clk;
  logic              ps2_data;
  logic [7:0]        rx_byte;
  logic              rx_strobe;
  logic              rx_err;
  logic [KEY_W-1:0]  ps2_key;

  // Device side: drives the lines, consumes bytes and key events
  modport master (
    output ps2_clk, ps2_data,
    input  rx_byte, rx_strobe, rx_err, ps2_key
  );

  // Receiver side
  modport slave (
    input  ps2_clk, ps2_data,
    output rx_byte, rx_strobe, rx_err, ps2_key
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a stability filter; idle level is high.
module ps2_line_filter #(
  parameter int unsigned FILT = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic line,
  output logic filt
);

  localparam int unsigned CW = (FILT > 2) ? $clog2(FILT) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // Filtered level follows only after FILT consecutive differing samples
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt   <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], line};
      if (sync_q[1] == filt) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILT - 1)) begin
        filt  <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_rx.sv
// PS/2 receiver: filters the lines, deserialises 11-bit frames and decodes
// set-2 prefixes into {toggle, pressed, extended, code} key events.
module ps2_host_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILT    = 8,
  parameter int unsigned TIMEOUT = 4000
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  ps2_host_rx_if.slave  ps2
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned BW = 3;

  logic clk_f, data_f, clk_prev_q, fall_c;

  ps2_line_filter #(.FILT(FILT)) u_clk_filt (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .line    (ps2.ps2_clk),
    .filt    (clk_f)
  );

  ps2_line_filter #(.FILT(FILT)) u_data_filt (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .line    (ps2.ps2_data),
    .filt    (data_f)
  );

  assign fall_c = clk_prev_q & ~clk_f;

  frame_state_e     state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic             par_q, par_d;
  logic [TW-1:0]    to_q, to_d;
  logic [7:0]       byte_q, byte_d;
  logic             stb_q, stb_d;
  logic             err_q, err_d;

  logic [KEY_W-1:0]  key_q, key_d;
  logic              ext_q, ext_d;
  logic              brk_q, brk_d;
  logic [SKIP_W-1:0] skip_q, skip_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      par_q      <= 1'b0;
      to_q       <= '0;
      byte_q     <= '0;
      stb_q      <= 1'b0;
      err_q      <= 1'b0;
      key_q      <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      skip_q     <= '0;
    end else begin
      clk_prev_q <= clk_f;
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      par_q      <= par_d;
      to_q       <= to_d;
      byte_q     <= byte_d;
      stb_q      <= stb_d;
      err_q      <= err_d;
      key_q      <= key_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      skip_q     <= skip_d;
    end
  end

  // Frame FSM: start, 8 data LSB first, odd parity, stop; watchdog on clock falls
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    par_d    = par_q;
    byte_d   = byte_q;
    stb_d    = 1'b0;
    err_d    = 1'b0;
    to_d     = (state_q == ST_IDLE || fall_c) ? '0 : to_q + 1'b1;

    if (state_q != ST_IDLE && !fall_c && to_q == TW'(TIMEOUT - 1)) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else if (fall_c) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_f) begin
            state_d  = ST_DATA;
            bitcnt_d = '0;
          end
        end
        ST_DATA: begin
          shreg_d = {data_f, shreg_q[7:1]};
          if (bitcnt_q == BW'(7)) state_d  = ST_PARITY;
          else                    bitcnt_d = bitcnt_q + 1'b1;
        end
        ST_PARITY: begin
          par_d   = data_f;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (par_q == ~^shreg_q && data_f) begin
            byte_d = shreg_q;
            stb_d  = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Set-2 decoder: prefixes persist across frames until a code consumes them
  always_comb begin
    key_d  = key_q;
    ext_d  = ext_q;
    brk_d  = brk_q;
    skip_d = skip_q;

    if (err_q) begin
      ext_d  = 1'b0;
      brk_d  = 1'b0;
      skip_d = '0;
    end else if (stb_q) begin
      if (skip_q != '0) begin
        skip_d = skip_q - 1'b1;
        if (skip_q == SKIP_W'(1)) key_d = {~key_q[KEY_TOGGLE], PAUSE_EVENT};
      end else if (byte_q == PS2_PAUSE) begin
        skip_d = PAUSE_SKIP;
      end else if (byte_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (byte_q == PS2_BRK) begin
        brk_d = 1'b1;
      end else if (ext_q && is_fake_shift(byte_q)) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (ext_q || brk_q || !is_reply_code(byte_q)) begin
        key_d[KEY_TOGGLE]  = ~key_q[KEY_TOGGLE];
        key_d[KEY_PRESSED] = ~brk_q;
        key_d[KEY_EXT]     = ext_q;
        key_d[7:0]         = byte_q;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  assign ps2.rx_byte   = byte_q;
  assign ps2.rx_strobe = stb_q;
  assign ps2.rx_err    = err_q;
  assign ps2.ps2_key   = key_q;

endmodule

// File: tb/tb_ps2_host_rx.sv
// Directed bench for ps2_host_rx: frames, prefixes, errors, timeout, glitches, reset.
module tb_ps2_host_rx;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;

  ps2_host_rx_if bus ();

  ps2_host_rx #(.FILT(8), .TIMEOUT(4000)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ps2     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_mis = 0;
  int n_stb = 0;
  int n_err = 0;
  int n_key = 0;
  logic [10:0] key_prev = '0;

  always @(negedge clk_sys) begin
    if (bus.rx_strobe === 1'b1) n_stb++;
    if (bus.rx_err === 1'b1) n_err++;
    if (bus.ps2_key !== key_prev) begin
      n_key++;
      key_prev = bus.ps2_key;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // One PS/2 bit: data set mid-high, 101-cycle low, optional 3-cycle glitch in high phase
  task automatic send_bit(input logic b, input logic glitch);
    bus.ps2_data = b;
    cyc(50);
    bus.ps2_clk = 1'b0;
    cyc(101);
    bus.ps2_clk = 1'b1;
    if (glitch) begin
      cyc(20);
      bus.ps2_clk = 1'b0;
      cyc(3);
      bus.ps2_clk = 1'b1;
      cyc(28);
    end else begin
      cyc(51);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic glitch);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch && (i == 3));
    send_bit((~^b) ^ bad_par, 1'b0);
    send_bit(1'b1, 1'b0);
    bus.ps2_data = 1'b1;
    cyc(200);
  endtask

  int s0, e0, k0, lat;

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    cyc(5);
    check("rst_rx_byte", 16'(bus.rx_byte), 16'h0000);
    check("rst_rx_strobe", 16'(bus.rx_strobe), 16'h0000);
    check("rst_rx_err", 16'(bus.rx_err), 16'h0000);
    check("rst_ps2_key", 16'(bus.ps2_key), 16'h0000);
    reset_n = 1'b1;
    cyc(20);

    // Single make code
    s0 = n_stb; e0 = n_err;
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t1_rx_byte", 16'(bus.rx_byte), 16'h001C);
    check("t1_key", 16'(bus.ps2_key), 16'h061C);
    check("t1_strobes", 16'(n_stb - s0), 16'd1);
    check("t1_errs", 16'(n_err - e0), 16'd0);

    // Extended break E0 F0 75
    s0 = n_stb; e0 = n_err; k0 = n_key;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    check("t2_strobes", 16'(n_stb - s0), 16'd3);
    check("t2_key", 16'(bus.ps2_key), 16'h0175);
    check("t2_key_events", 16'(n_key - k0), 16'd1);
    check("t2_rx_byte", 16'(bus.rx_byte), 16'h0075);
    check("t2_errs", 16'(n_err - e0), 16'd0);

    // Parity error leaves byte and key alone
    s0 = n_stb; e0 = n_err;
    send_frame(8'h1C, 1'b1, 1'b0);
    check("t3_errs", 16'(n_err - e0), 16'd1);
    check("t3_strobes", 16'(n_stb - s0), 16'd0);
    check("t3_rx_byte", 16'(bus.rx_byte), 16'h0075);
    check("t3_key", 16'(bus.ps2_key), 16'h0175);

    // Error after E0 drops the prefix
    s0 = n_stb; e0 = n_err;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t3b_key", 16'(bus.ps2_key), 16'h061C);
    check("t3b_errs", 16'(n_err - e0), 16'd1);
    check("t3b_strobes", 16'(n_stb - s0), 16'd2);

    // Timeout: five falls then the clock stays high
    e0 = n_err;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    bus.ps2_data = 1'b0;
    cyc(50);
    bus.ps2_clk = 1'b0;
    lat = 0;
    for (int i = 1; i <= 6000; i++) begin
      @(negedge clk_sys);
      if (i == 101) begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
      end
      if (bus.rx_err === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("t4_timeout_window", 16'(lat >= 4000 && lat <= 4020), 16'd1);
    cyc(50);
    check("t4_errs", 16'(n_err - e0), 16'd1);
    send_frame(8'h29, 1'b0, 1'b0);
    check("t4_key", 16'(bus.ps2_key), 16'h0229);
    check("t4_rx_byte", 16'(bus.rx_byte), 16'h0029);

    // Clock glitches in idle and mid-frame
    s0 = n_stb; e0 = n_err;
    bus.ps2_clk = 1'b0;
    cyc(3);
    bus.ps2_clk = 1'b1;
    cyc(50);
    send_frame(8'h4B, 1'b0, 1'b1);
    check("t5_rx_byte", 16'(bus.rx_byte), 16'h004B);
    check("t5_key", 16'(bus.ps2_key), 16'h064B);
    check("t5_strobes", 16'(n_stb - s0), 16'd1);
    check("t5_errs", 16'(n_err - e0), 16'd0);

    // Pause sequence collapses to one event
    s0 = n_stb; k0 = n_key;
    send_frame(8'hE1, 1'b0, 1'b0);
    send_frame(8'h14, 1'b0, 1'b0);
    send_frame(8'h77, 1'b0, 1'b0);
    send_frame(8'hE1, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h14, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h77, 1'b0, 1'b0);
    check("t6_key", 16'(bus.ps2_key), 16'h0377);
    check("t6_key_events", 16'(n_key - k0), 16'd1);
    check("t6_strobes", 16'(n_stb - s0), 16'd8);
    check("t6_rx_byte", 16'(bus.rx_byte), 16'h0077);

    // Reset mid-frame
    e0 = n_err;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    bus.ps2_data = 1'b1;
    reset_n = 1'b0;
    cyc(2);
    check("t7_rst_rx_byte", 16'(bus.rx_byte), 16'h0000);
    check("t7_rst_rx_strobe", 16'(bus.rx_strobe), 16'h0000);
    check("t7_rst_rx_err", 16'(bus.rx_err), 16'h0000);
    check("t7_rst_key", 16'(bus.ps2_key), 16'h0000);
    cyc(10);
    reset_n = 1'b1;
    cyc(50);
    send_frame(8'h5A, 1'b0, 1'b0);
    check("t7_key", 16'(bus.ps2_key), 16'h065A);
    check("t7_rx_byte", 16'(bus.rx_byte), 16'h005A);
    check("t7_errs", 16'(n_err - e0), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
